dp_microseq: RTL and testbench

//  Microprogrammed sequencer for the register-file/ALU datapath. Stores control words
//  {DA[15:13],AA[12:10],BA[9:7],MB[6],FS[5:2],MD[1],RW[0]} with next-address fields.

---
 rtl/dp_microseq.sv | 113 +++++++++++
 tb/tb_dp_microseq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_microseq.sv
// Microprogrammed sequencer: issues one stored control word per clock to the
// register-file/ALU datapath, branching on the datapath's V/C/N/Z status.
module dp_microseq #(
    parameter int ADDR_W    = 4,
    parameter int CNT_W     = 8,
    parameter int MAX_STEPS = 255
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [18+ADDR_W:0]  prog_data,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic                stop,
    input  logic                V,
    input  logic                C,
    input  logic                N,
    input  logic                Z,
    output logic [15:0]         CTRWRD,
    output logic [ADDR_W-1:0]   upc,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic                prog_err,
    output logic [CNT_W-1:0]    step_cnt
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int WORD_W = 19 + ADDR_W;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    typedef enum logic [2:0] {
        C_NEXT, C_JMP, C_BZ, C_BN, C_BC, C_BV, C_BNZ, C_HALT
    } cond_t;

    state_t              state;
    logic [WORD_W-1:0]   mem [DEPTH];
    logic [WORD_W-1:0]   word;
    cond_t               cond;
    logic [ADDR_W-1:0]   baddr;
    logic [ADDR_W-1:0]   upc_next;
    logic                taken;
    logic [CNT_W-1:0]    cnt_inc;

    always_comb begin
        word     = mem[upc];
        cond     = cond_t'(word[ADDR_W+2:ADDR_W]);
        baddr    = word[ADDR_W-1:0];
        cnt_inc  = step_cnt + 1'b1;
        taken    = 1'b0;
        case (cond)
            C_JMP:   taken = 1'b1;
            C_BZ:    taken = Z;
            C_BN:    taken = N;
            C_BC:    taken = C;
            C_BV:    taken = V;
            C_BNZ:   taken = ~Z;
            default: taken = 1'b0;
        endcase
        upc_next = taken ? baddr : upc + 1'b1;
    end

    always_comb begin
        CTRWRD = (state == RUN && cond != C_HALT) ? word[WORD_W-1 -: 16] : '0;
        busy   = (state == RUN);
        done   = (state == HALT);
    end

    // Program store has no reset; writes are locked out while running.
    always_ff @(posedge CLK) begin
        if (prog_we && state != RUN)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            upc      <= '0;
            step_cnt <= '0;
            timeout  <= 1'b0;
            prog_err <= 1'b0;
        end else begin
            prog_err <= (state == RUN) && prog_we;
            case (state)
                RUN: begin
                    if (cond == C_HALT) begin
                        state <= HALT;
                    end else begin
                        step_cnt <= cnt_inc;
                        upc      <= upc_next;
                        // Watchdog outranks stop; both still let this word complete.
                        if (cnt_inc == CNT_W'(MAX_STEPS)) begin
                            state   <= HALT;
                            timeout <= 1'b1;
                        end else if (stop) begin
                            state <= HALT;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state    <= RUN;
                        upc      <= start_addr;
                        step_cnt <= '0;
                        timeout  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_microseq.sv
// Self-checking bench for dp_microseq: a run-level model tracks the expected
// outputs every cycle, and directed scenarios pin hand-computed values.
module tb_dp_microseq;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [22:0] prog_data;
    logic        start;
    logic [3:0]  start_addr;
    logic        stop;
    logic        V, C, N, Z;
    logic [15:0] CTRWRD;
    logic [3:0]  upc;
    logic        busy, done, timeout, prog_err;
    logic [7:0]  step_cnt;

    localparam int MAXS = 8;

    int tests = 0;
    int fails = 0;

    dp_microseq #(.ADDR_W(4), .CNT_W(8), .MAX_STEPS(MAXS)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .start_addr(start_addr), .stop(stop),
        .V(V), .C(C), .N(N), .Z(Z), .CTRWRD(CTRWRD), .upc(upc), .busy(busy),
        .done(done), .timeout(timeout), .prog_err(prog_err), .step_cnt(step_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Run-level model: program image plus "running / finished" flags.
    logic [15:0] m_cw   [16];
    logic [2:0]  m_cond [16];
    logic [3:0]  m_ba   [16];
    logic        m_run, m_done, m_to, m_perr, take;
    logic [3:0]  m_pc;
    logic [7:0]  m_steps;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_run = 0; m_done = 0; m_to = 0; m_perr = 0; m_pc = 0; m_steps = 0;
        end else begin
            m_perr = 0;
            if (m_run) begin
                if (prog_we) m_perr = 1;
                if (m_cond[m_pc] == 3'd7) begin
                    m_run = 0; m_done = 1;
                end else begin
                    case (m_cond[m_pc])
                        3'd1: take = 1;
                        3'd2: take = Z;
                        3'd3: take = N;
                        3'd4: take = C;
                        3'd5: take = V;
                        3'd6: take = !Z;
                        default: take = 0;
                    endcase
                    m_steps = m_steps + 1;
                    m_pc = take ? m_ba[m_pc] : m_pc + 4'd1;
                    if (m_steps == MAXS) begin
                        m_run = 0; m_done = 1; m_to = 1;
                    end else if (stop) begin
                        m_run = 0; m_done = 1;
                    end
                end
            end else begin
                if (prog_we) begin
                    m_cw[prog_addr]   = prog_data[22:7];
                    m_cond[prog_addr] = prog_data[6:4];
                    m_ba[prog_addr]   = prog_data[3:0];
                end
                if (start) begin
                    m_run = 1; m_done = 0; m_pc = start_addr; m_steps = 0; m_to = 0;
                end
            end
        end
    end

    logic [15:0] exp_cw;
    always @(negedge CLK) begin
        exp_cw = (m_run && m_cond[m_pc] != 3'd7) ? m_cw[m_pc] : 16'h0000;
        chk("m_ctrwrd", CTRWRD, exp_cw);
        chk("m_upc", upc, m_pc);
        chk("m_busy", busy, m_run);
        chk("m_done", done, m_done);
        chk("m_step_cnt", step_cnt, m_steps);
        chk("m_timeout", timeout, m_to);
        chk("m_prog_err", prog_err, m_perr);
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] cw,
                        input logic [2:0] cd, input logic [3:0] ba);
        prog_addr = a;
        prog_data = {cw, cd, ba};
        prog_we   = 1;
        step();
        prog_we   = 0;
    endtask

    task automatic run_from(input logic [3:0] a);
        start_addr = a;
        start      = 1;
        step();
        start      = 0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            step();
        end
        chk("done_wait", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        RESET_N = 0; prog_we = 0; prog_addr = 0; prog_data = 0; start = 0;
        start_addr = 0; stop = 0; V = 0; C = 0; N = 0; Z = 0;
        step();
        chk("rst_ctrwrd", CTRWRD, 16'h0000);
        chk("rst_upc", upc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_step_cnt", step_cnt, 0);
        RESET_N = 1;

        for (int i = 0; i < 16; i++) load(4'(i), 16'h0000, 3'd7, 4'd0);

        // Straight-line program ending in HALT
        load(0, 16'h2003, 3'd0, 0);
        load(1, 16'h4003, 3'd0, 0);
        load(2, 16'h0000, 3'd7, 0);
        run_from(0);
        chk("t1_w0", CTRWRD, 16'h2003);
        step();
        chk("t1_w1", CTRWRD, 16'h4003);
        step();
        chk("t1_haltword", CTRWRD, 16'h0000);
        step();
        chk("t1_done", done, 1);
        chk("t1_steps", step_cnt, 2);
        chk("t1_timeout", timeout, 0);

        // Conditional branch on Z, taken then not taken
        load(0, 16'h0005, 3'd2, 4'd5);
        Z = 1;
        run_from(0);
        chk("t2_w0", CTRWRD, 16'h0005);
        step();
        chk("t2_taken_upc", upc, 5);
        wait_done();
        Z = 0;
        run_from(0);
        step();
        chk("t2_fall_upc", upc, 1);
        chk("t2_fall_cw", CTRWRD, 16'h4003);
        wait_done();

        // Address wrap from the top word
        load(15, 16'h0003, 3'd0, 0);
        run_from(15);
        chk("t3_upc15", upc, 15);
        chk("t3_cw", CTRWRD, 16'h0003);
        step();
        chk("t3_wrap", upc, 0);
        wait_done();

        // Endless loop stopped by the watchdog
        load(3, 16'h0109, 3'd1, 4'd3);
        run_from(3);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            if (CTRWRD == 16'h0109) n++;
            step();
        end
        chk("t4_words", n, MAXS);
        chk("t4_done", done, 1);
        chk("t4_timeout", timeout, 1);
        chk("t4_steps", step_cnt, MAXS);

        // Same loop halted by stop, with a rejected program write
        run_from(3);
        step();
        step();
        stop = 1;
        prog_addr = 3; prog_data = {16'hBEEF, 3'd7, 4'd0}; prog_we = 1;
        step();
        stop = 0; prog_we = 0;
        chk("t5_done", done, 1);
        chk("t5_steps", step_cnt, 3);
        chk("t5_timeout", timeout, 0);
        chk("t5_prog_err", prog_err, 1);
        step();
        chk("t5_prog_err_clr", prog_err, 0);
        run_from(3);
        chk("t5_mem_kept", CTRWRD, 16'h0109);
        stop = 1;
        step();
        stop = 0;
        wait_done();

        // Asynchronous reset in the middle of a run
        run_from(3);
        step();
        #2 RESET_N = 0;
        #1;
        chk("t6_ctrwrd", CTRWRD, 16'h0000);
        chk("t6_busy", busy, 0);
        chk("t6_upc", upc, 0);
        step();
        RESET_N = 1;
        run_from(0);
        chk("t6_rerun_w0", CTRWRD, 16'h0005);
        step();
        chk("t6_rerun_w1", CTRWRD, 16'h4003);
        wait_done();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
